// File: rtl/keccak_padder_multirate.sv
// Keccak/SHA3 input padder with per-message rate selection.
// Packs 64-bit message words into a rate-sized block, applies multi-rate
// padding (PAD_BYTE ... 0x80) on the last word and hands the block to the
// permutation core over a valid/ack handshake.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_ACCUM  | collecting words into the block buffer
//   ST_FULL   | block presented (out_ready=1); input words are dropped
module keccak_padder_multirate #(
  parameter int         LANE_W    = 64,
  parameter int         MAX_LANES = 18,
  parameter logic [7:0] PAD_BYTE  = 8'h06
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        mode,
  input  logic [LANE_W-1:0]                 in,
  input  logic                              in_ready,
  input  logic                              is_last,
  input  logic [$clog2(LANE_W/8)-1:0]       byte_num,
  output logic                              buffer_full,
  output logic [MAX_LANES*LANE_W-1:0]       out,
  output logic                              out_ready,
  output logic                              out_last,
  input  logic                              out_ack
);

  localparam int NB = LANE_W / 8;
  localparam int CW = $clog2(MAX_LANES);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     lane_cnt_q, lane_cnt_d;
  logic [LANE_W-1:0] lanes_q [MAX_LANES];
  logic [LANE_W-1:0] lanes_d [MAX_LANES];
  logic [1:0]        mode_q, mode_d;
  logic              in_msg_q, in_msg_d;
  logic              last_q, last_d;

  logic [CW-1:0]     rate;
  logic [CW-1:0]     rate_m1;
  logic [LANE_W-1:0] padded;

  // Rate in lanes for each SHA3 variant (224/256/384/512).
  function automatic logic [CW-1:0] rate_lanes(input logic [1:0] m);
    case (m)
      2'd0:    rate_lanes = CW'(MAX_LANES);
      2'd1:    rate_lanes = CW'(17);
      2'd2:    rate_lanes = CW'(13);
      default: rate_lanes = CW'(9);
    endcase
  endfunction

  // Last-word byte masking: keep bytes below byte_num, insert pad byte, zero the rest.
  always_comb begin
    padded = '0;
    for (int k = 0; k < NB; k++) begin
      if (k < int'(byte_num))
        padded[LANE_W-1-8*k -: 8] = in[LANE_W-1-8*k -: 8];
      else if (k == int'(byte_num))
        padded[LANE_W-1-8*k -: 8] = PAD_BYTE;
    end
  end

  // Next-state logic: accumulate, pad, hold for the consumer, clear on ack.
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    lanes_d    = lanes_q;
    mode_d     = mode_q;
    in_msg_d   = in_msg_q;
    last_d     = last_q;
    // The first word of a message sees the live mode before it is latched.
    rate       = in_msg_q ? rate_lanes(mode_q) : rate_lanes(mode);
    rate_m1    = rate - CW'(1);

    if (state_q == ST_ACCUM) begin
      if (in_ready) begin
        if (!in_msg_q) begin
          mode_d   = mode;
          in_msg_d = 1'b1;
        end
        for (int i = 0; i < MAX_LANES; i++)
          if (CW'(i) == lane_cnt_q)
            lanes_d[i] = is_last ? padded : in;
        if (is_last) begin
          // Lanes past the last word are already zero since the buffer is
          // cleared on every ack; only the closing 0x80 needs adding.
          for (int i = 0; i < MAX_LANES; i++)
            if (CW'(i) == rate_m1)
              lanes_d[i][7:0] = lanes_d[i][7:0] | 8'h80;
          state_d    = ST_FULL;
          last_d     = 1'b1;
          in_msg_d   = 1'b0;
          lane_cnt_d = '0;
        end else if (lane_cnt_q == rate_m1) begin
          state_d    = ST_FULL;
          last_d     = 1'b0;
          lane_cnt_d = '0;
        end else begin
          lane_cnt_d = lane_cnt_q + CW'(1);
        end
      end
    end else if (out_ack) begin
      state_d = ST_ACCUM;
      last_d  = 1'b0;
      for (int i = 0; i < MAX_LANES; i++)
        lanes_d[i] = '0;
    end
  end

  // State and block buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ACCUM;
      lane_cnt_q <= '0;
      lanes_q    <= '{default: '0};
      mode_q     <= 2'd0;
      in_msg_q   <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      lanes_q    <= lanes_d;
      mode_q     <= mode_d;
      in_msg_q   <= in_msg_d;
      last_q     <= last_d;
    end
  end

  // Flatten lanes onto the output bus, lane 0 in the MSBs.
  always_comb begin
    out = '0;
    for (int i = 0; i < MAX_LANES; i++)
      out[(MAX_LANES-i)*LANE_W-1 -: LANE_W] = lanes_q[i];
  end

  assign out_ready   = (state_q == ST_FULL);
  assign buffer_full = (state_q == ST_FULL);
  assign out_last    = last_q;

endmodule

// File: tb/tb_keccak_padder_multirate.sv
// Directed bench for keccak_padder_multirate: single-word pad, full-lane pad
// merge, exact-rate-multiple messages, backpressure, mode latching and reset.
module tb_keccak_padder_multirate;

  localparam int LW = 64;
  localparam int ML = 18;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      mode;
  logic [LW-1:0]   in_w;
  logic            in_ready;
  logic            is_last;
  logic [2:0]      byte_num;
  logic            buffer_full;
  logic [ML*LW-1:0] out_w;
  logic            out_ready;
  logic            out_last;
  logic            out_ack;

  int checks   = 0;
  int failures = 0;

  keccak_padder_multirate dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .in         (in_w),
    .in_ready   (in_ready),
    .is_last    (is_last),
    .byte_num   (byte_num),
    .buffer_full(buffer_full),
    .out        (out_w),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_ack    (out_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lane_of(input int i);
    return out_w[(ML-i)*LW-1 -: LW];
  endfunction

  function automatic logic lanes_zero(input int lo, input int hi);
    logic z;
    z = 1'b1;
    for (int i = lo; i <= hi; i++)
      if (lane_of(i) !== '0) z = 1'b0;
    return z;
  endfunction

  // Presents one word for exactly one clock; called at a negedge, returns at the next.
  task automatic drive(input logic [LW-1:0] w, input logic last, input logic [2:0] bn);
    in_w = w; is_last = last; byte_num = bn; in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0; is_last = 1'b0;
  endtask

  task automatic ack_block(input string name);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL %s_ack_ready got=%0b want=0", name, out_ready); end
    checks++; if (out_w !== '0) begin failures++; $display("FAIL %s_ack_clear out not zero after ack", name); end
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'd0; in_w = '0; in_ready = 1'b0; is_last = 1'b0;
    byte_num = '0; out_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_w !== '0) begin failures++; $display("FAIL reset_out not zero"); end
    checks++; if ({out_ready, out_last, buffer_full} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {out_ready, out_last, buffer_full}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    mode = 2'd1;
    drive(64'h0102030405060708, 1'b1, 3'd3);
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL single_latency out_ready got=%0b want=1", out_ready); end
    checks++; if (lane_of(0) !== 64'h0102030600000000) begin failures++; $display("FAIL single_lane0 got=%h want=0102030600000000", lane_of(0)); end
    checks++; if (!lanes_zero(1, 15)) begin failures++; $display("FAIL single_mid_lanes not zero"); end
    checks++; if (lane_of(16) !== 64'h80) begin failures++; $display("FAIL single_lane16 got=%h want=80", lane_of(16)); end
    checks++; if (lane_of(17) !== '0) begin failures++; $display("FAIL single_lane17 got=%h want=0", lane_of(17)); end
    checks++; if ({out_last, buffer_full} !== 2'b11) begin failures++; $display("FAIL single_flags got=%b want=11", {out_last, buffer_full}); end
    ack_block("single");
  endtask

  task automatic test_full_last_lane();
    mode = 2'd3;
    for (int i = 0; i < 8; i++) drive(64'h1000 + 64'(i), 1'b0, 3'd0);
    checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL m3_early_ready got=%0b want=0", out_ready); end
    drive(64'hAABBCCDDEEFF1122, 1'b1, 3'd7);
    checks++; if (lane_of(8) !== 64'hAABBCCDDEEFF1186) begin failures++; $display("FAIL m3_lane8 got=%h want=aabbccddeeff1186", lane_of(8)); end
    checks++; if (lane_of(3) !== 64'h1003) begin failures++; $display("FAIL m3_lane3 got=%h want=1003", lane_of(3)); end
    checks++; if (!lanes_zero(9, 17)) begin failures++; $display("FAIL m3_unused_lanes not zero"); end
    checks++; if ({out_ready, out_last} !== 2'b11) begin failures++; $display("FAIL m3_flags got=%b want=11", {out_ready, out_last}); end
    ack_block("m3");
  endtask

  task automatic test_exact_multiple();
    mode = 2'd0;
    for (int i = 0; i < 18; i++) drive(64'hF000 + 64'(i), 1'b0, 3'd0);
    checks++; if ({out_ready, out_last} !== 2'b10) begin failures++; $display("FAIL exact_blk1_flags got=%b want=10", {out_ready, out_last}); end
    checks++; if (lane_of(17) !== 64'hF011) begin failures++; $display("FAIL exact_blk1_lane17 got=%h want=f011", lane_of(17)); end
    ack_block("exact1");
    mode = 2'd2;  // must be ignored: message already in progress in mode 0
    drive(64'hDEADBEEFDEADBEEF, 1'b1, 3'd0);
    checks++; if (lane_of(0) !== 64'h0600000000000000) begin failures++; $display("FAIL exact_blk2_lane0 got=%h want=0600000000000000", lane_of(0)); end
    checks++; if (lane_of(17) !== 64'h80) begin failures++; $display("FAIL exact_blk2_lane17 got=%h want=80", lane_of(17)); end
    checks++; if (lane_of(12) !== '0) begin failures++; $display("FAIL exact_blk2_lane12 got=%h want=0", lane_of(12)); end
    checks++; if ({out_ready, out_last} !== 2'b11) begin failures++; $display("FAIL exact_blk2_flags got=%b want=11", {out_ready, out_last}); end
    ack_block("exact2");
  endtask

  task automatic test_back_to_back();
    logic held_ok;
    mode = 2'd3;
    for (int i = 0; i < 9; i++) drive(64'h5500 + 64'(i), 1'b0, 3'd0);
    checks++; if ({out_ready, out_last} !== 2'b10) begin failures++; $display("FAIL bp_fill_flags got=%b want=10", {out_ready, out_last}); end
    held_ok = 1'b1;
    in_ready = 1'b1; is_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_w = 64'h9900 + 64'(c);
      @(negedge clk);
      if (buffer_full !== 1'b1 || lane_of(0) !== 64'h5500 || lane_of(8) !== 64'h5508) held_ok = 1'b0;
    end
    checks++; if (held_ok !== 1'b1) begin failures++; $display("FAIL bp_hold got=%0b want=1 (buffer_full/out changed)", held_ok); end
    in_w = 64'hBAD0BAD0BAD0BAD0; out_ack = 1'b1;  // word offered alongside ack is dropped
    @(negedge clk);
    in_ready = 1'b0; out_ack = 1'b0;
    checks++; if (buffer_full !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b want=0", buffer_full); end
    drive(64'h1122334455667788, 1'b1, 3'd7);
    checks++; if (lane_of(0) !== 64'h1122334455667706) begin failures++; $display("FAIL bp_next_lane0 got=%h want=1122334455667706", lane_of(0)); end
    checks++; if (lane_of(8) !== 64'h80) begin failures++; $display("FAIL bp_next_lane8 got=%h want=80", lane_of(8)); end
    ack_block("bp");
  endtask

  task automatic test_mode_change();
    mode = 2'd2;
    drive(64'h7000, 1'b0, 3'd0);
    mode = 2'd3;
    for (int i = 1; i < 9; i++) drive(64'h7000 + 64'(i), 1'b0, 3'd0);
    checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL modechg_9_ready got=%0b want=0", out_ready); end
    out_ack = 1'b1;  // ack while accumulating has no effect
    for (int i = 9; i < 12; i++) drive(64'h7000 + 64'(i), 1'b0, 3'd0);
    out_ack = 1'b0;
    checks++; if (lane_of(10) !== 64'h700A) begin failures++; $display("FAIL modechg_lane10 got=%h want=700a", lane_of(10)); end
    drive(64'h0, 1'b1, 3'd0);
    checks++; if (lane_of(12) !== 64'h0600000000000080) begin failures++; $display("FAIL modechg_lane12 got=%h want=0600000000000080", lane_of(12)); end
    checks++; if ({out_ready, out_last} !== 2'b11) begin failures++; $display("FAIL modechg_flags got=%b want=11", {out_ready, out_last}); end
    ack_block("modechg");
  endtask

  task automatic test_reset_mid();
    logic [ML*LW-1:0] exp;
    mode = 2'd3;
    for (int i = 0; i < 5; i++) drive(64'h3300 + 64'(i), 1'b0, 3'd0);
    #2 reset = 1'b1;
    #1;
    checks++; if (out_w !== '0) begin failures++; $display("FAIL rstmid_async_out not zero"); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(64'hCAFEBABE12345678, 1'b1, 3'd2);
    exp = '0;
    exp[ML*LW-1 -: LW] = 64'hCAFE060000000000;
    exp[(ML-8)*LW-1 -: LW] = 64'h80;
    checks++; if (out_w !== exp) begin failures++; $display("FAIL rstmid_block got lane0=%h lane8=%h want lane0=cafe060000000000 lane8=80 rest 0", lane_of(0), lane_of(8)); end
    checks++; if ({out_ready, out_last} !== 2'b11) begin failures++; $display("FAIL rstmid_flags got=%b want=11", {out_ready, out_last}); end
    ack_block("rstmid");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_last_lane();
    test_exact_multiple();
    test_back_to_back();
    test_mode_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
